// File: rtl/pixel_store_if.sv
// Plot request handshake between a drawing client and pixel_store.
// A transfer happens on a cycle with plot=1 and ready=1.
interface pixel_store_if;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot;
  logic       ready;

  modport master (
    output plot_x, plot_y, plot_colour, plot,
    input  ready
  );

  modport slave (
    input  plot_x, plot_y, plot_colour, plot,
    output ready
  );
endinterface

// File: rtl/pixel_store.sv
// Frame store with read-modify-write plotting, bulk clear,
// sticky overlap detection and an independent raster scan port.
module pixel_store #(
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] BG_COLOUR = 3'd0
) (
  input  logic       clock,
  input  logic       resetn,
  pixel_store_if.slave pif,
  input  logic       clear_screen,
  output logic       clearing,
  output logic       collision,
  input  logic       clear_collision,
  input  logic       scan_en,
  output logic [7:0] scan_x,
  output logic [6:0] scan_y,
  output logic [2:0] scan_colour,
  output logic       scan_valid,
  output logic       frame_start
);

  localparam int         DEPTH = SCREEN_W * SCREEN_H;
  localparam logic [14:0] LAST  = 15'(DEPTH - 1);
  localparam logic [7:0] XLAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] YLAST = 7'(SCREEN_H - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RMW_RD = 2'd1;
  localparam logic [1:0] S_RMW_WR = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;

  function automatic logic [14:0] addr_of(
    input logic [7:0] x,
    input logic [6:0] y
  );
    return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction

  logic [2:0]  mem_q [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [2:0]  col_q, col_d;
  logic [14:0] clr_q, clr_d;
  logic [2:0]  old_q;
  logic        coll_q, coll_d;

  logic        we;
  logic [14:0] wa;
  logic [2:0]  wd;
  logic        in_range;
  logic        coll_set;
  logic        clr_start;

  logic [7:0]  sx_q;
  logic [6:0]  sy_q;
  logic [7:0]  scan_x_q;
  logic [6:0]  scan_y_q;
  logic [2:0]  scan_col_q;
  logic        scan_valid_q;
  logic        frame_q;

  assign in_range = (pif.plot_x <= XLAST)
                 && (pif.plot_y <= YLAST);

  assign pif.ready   = (state_q == S_IDLE);
  assign clearing    = (state_q == S_CLEAR);
  assign collision   = coll_q;
  assign scan_x      = scan_x_q;
  assign scan_y      = scan_y_q;
  assign scan_colour = scan_col_q;
  assign scan_valid  = scan_valid_q;
  assign frame_start = frame_q;

  // Write FSM next state, store write port and collision update
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    col_d     = col_q;
    clr_d     = clr_q;
    we        = 1'b0;
    wa        = addr_q;
    wd        = col_q;
    coll_set  = 1'b0;
    clr_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clear_screen) begin
          state_d   = S_CLEAR;
          clr_d     = '0;
          clr_start = 1'b1;
        end else if (pif.plot && in_range) begin
          state_d = S_RMW_RD;
          addr_d  = addr_of(pif.plot_x, pif.plot_y);
          col_d   = pif.plot_colour;
        end
      end
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: begin
        we       = 1'b1;
        state_d  = S_IDLE;
        coll_set = (old_q != BG_COLOUR)
                && (col_q != BG_COLOUR);
      end
      S_CLEAR: begin
        we = 1'b1;
        wa = clr_q;
        wd = BG_COLOUR;
        if (clr_q == LAST) state_d = S_IDLE;
        else clr_d = clr_q + 15'd1;
      end
      default: state_d = S_IDLE;
    endcase
    coll_d = coll_q;
    if (coll_set) coll_d = 1'b1;
    else if (clr_start || clear_collision) coll_d = 1'b0;
  end

  // FSM registers; old entry is sampled every cycle, used in RMW_WR
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      clr_q   <= '0;
      old_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      clr_q   <= clr_d;
      old_q   <= mem_q[addr_q];
      coll_q  <= coll_d;
    end
  end

  // Store write port; reset suppresses a pending write
  always_ff @(posedge clock) begin
    if (we && resetn) mem_q[wa] <= wd;
  end

  // Raster scan: read (sx,sy), present it one cycle later
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sx_q         <= '0;
      sy_q         <= '0;
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      scan_col_q   <= '0;
      scan_valid_q <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      scan_valid_q <= scan_en;
      frame_q      <= scan_en && (sx_q == 8'd0)
                              && (sy_q == 7'd0);
      if (scan_en) begin
        scan_x_q   <= sx_q;
        scan_y_q   <= sy_q;
        scan_col_q <= mem_q[addr_of(sx_q, sy_q)];
        if (sx_q == XLAST) begin
          sx_q <= '0;
          sy_q <= (sy_q == YLAST) ? 7'd0 : sy_q + 7'd1;
        end else begin
          sx_q <= sx_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_store.sv
// Random and directed bench for pixel_store with a scan scoreboard
// and a frame-level reference model of the store.
module tb_pixel_store;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  typedef struct {
    int x;
    int y;
    int c;
    int fs;
  } exp_t;

  logic       clock;
  logic       resetn;
  logic       clear_screen;
  logic       clearing;
  logic       collision;
  logic       clear_collision;
  logic       scan_en;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic [2:0] scan_colour;
  logic       scan_valid;
  logic       frame_start;

  pixel_store_if pif ();

  pixel_store dut (
    .clock           (clock),
    .resetn          (resetn),
    .pif             (pif),
    .clear_screen    (clear_screen),
    .clearing        (clearing),
    .collision       (collision),
    .clear_collision (clear_collision),
    .scan_en         (scan_en),
    .scan_x          (scan_x),
    .scan_y          (scan_y),
    .scan_colour     (scan_colour),
    .scan_valid      (scan_valid),
    .frame_start     (frame_start)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   ref_mem[N];
  int   ref_coll = 0;
  int   scan_idx = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare every presented scan pixel
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (scan_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scan_unexpected: scan_valid=1 with no strobe");
        end else begin
          e = sb.pop_front();
          if (int'(scan_x) != e.x || int'(scan_y) != e.y ||
              int'(scan_colour) != e.c || int'(frame_start) != e.fs) begin
            errors++;
            $display("FAIL scan_pixel: got (%0d,%0d) c=%0d fs=%0d expected (%0d,%0d) c=%0d fs=%0d",
                     scan_x, scan_y, scan_colour, frame_start,
                     e.x, e.y, e.c, e.fs);
          end
        end
      end
    end
  end

  task automatic do_plot(input int x, input int y, input int c,
                         input bit hold_cc);
    int n;
    int a;
    n = 0;
    @(negedge clock);
    while (!pif.ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!pif.ready) chk("plot_wait_ready", 0, 1);
    pif.plot_x      = 8'(x);
    pif.plot_y      = 7'(y);
    pif.plot_colour = 3'(c);
    pif.plot        = 1'b1;
    clear_collision = hold_cc;
    @(negedge clock);
    pif.plot = 1'b0;
    if (x < W && y < H) begin
      chk("busy_rmw_rd", int'(pif.ready), 0);
      @(negedge clock);
      chk("busy_rmw_wr", int'(pif.ready), 0);
      @(negedge clock);
      a = y * W + x;
      if (ref_mem[a] != 0 && c != 0) ref_coll = 1;
      else if (hold_cc) ref_coll = 0;
      ref_mem[a] = c;
    end else begin
      if (hold_cc) ref_coll = 0;
    end
    clear_collision = 1'b0;
    chk("ready_after_plot", int'(pif.ready), 1);
    chk("collision", int'(collision), ref_coll);
  endtask

  task automatic pulse_clear_collision();
    @(negedge clock);
    clear_collision = 1'b1;
    @(negedge clock);
    clear_collision = 1'b0;
    ref_coll = 0;
    chk("clear_collision", int'(collision), 0);
  endtask

  task automatic do_clear();
    int n;
    int busy;
    n = 0;
    busy = 0;
    @(negedge clock);
    clear_screen = 1'b1;
    @(negedge clock);
    clear_screen = 1'b0;
    while (clearing && n < 20000) begin
      if (pif.ready) busy++;
      n++;
      @(negedge clock);
    end
    chk("clear_cycles", n, N);
    chk("ready_low_in_clear", busy, 0);
    chk("ready_after_clear", int'(pif.ready), 1);
    chk("collision_after_clear", int'(collision), 0);
    for (int i = 0; i < N; i++) ref_mem[i] = 0;
    ref_coll = 0;
  endtask

  task automatic do_scan(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      scan_en = 1'b1;
      e.x  = scan_idx % W;
      e.y  = scan_idx / W;
      e.c  = ref_mem[scan_idx];
      e.fs = (scan_idx == 0) ? 1 : 0;
      sb.push_back(e);
      scan_idx = (scan_idx + 1) % N;
    end
    @(negedge clock);
    scan_en = 1'b0;
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    resetn          = 1'b0;
    clear_screen    = 1'b0;
    clear_collision = 1'b0;
    scan_en         = 1'b0;
    pif.plot        = 1'b0;
    pif.plot_x      = '0;
    pif.plot_y      = '0;
    pif.plot_colour = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready", int'(pif.ready), 1);
    chk("rst_clearing", int'(clearing), 0);
    chk("rst_collision", int'(collision), 0);
    chk("rst_scan_valid", int'(scan_valid), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_scan_xyc", int'({scan_x, scan_y, scan_colour}), 0);
    resetn = 1'b1;
    @(negedge clock);
    chk("ready_after_release", int'(pif.ready), 1);

    do_clear();
    do_scan(N);

    do_plot(10, 58, 2, 1'b0);
    do_plot(160, 5, 3, 1'b0);
    do_plot(5, 120, 3, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0)
        do_plot($urandom_range(20, 27), $urandom_range(40, 43),
                $urandom_range(0, 7), $urandom_range(0, 5) == 0);
      else
        do_plot($urandom_range(0, 169), $urandom_range(0, 124),
                $urandom_range(0, 7), $urandom_range(0, 5) == 0);
    end
    do_scan(N + 1);

    pulse_clear_collision();
    do_plot(10, 58, 0, 1'b0);
    do_plot(10, 58, 2, 1'b0);
    chk("no_overlap_on_bg", int'(collision), 0);
    do_plot(10, 58, 4, 1'b0);
    chk("overlap_sets", int'(collision), 1);
    pulse_clear_collision();
    do_plot(10, 58, 0, 1'b0);
    chk("bg_replot_no_coll", int'(collision), 0);
    do_plot(10, 58, 5, 1'b1);
    chk("set_beats_clear", int'(collision), 0);
    do_plot(10, 58, 6, 1'b1);
    chk("set_beats_clear2", int'(collision), 1);

    do_plot(99, 0, 5, 1'b0);
    do_plot(100, 0, 6, 1'b0);
    do_plot(101, 0, 7, 1'b0);
    @(negedge clock);
    clear_screen = 1'b1;
    @(negedge clock);
    clear_screen = 1'b0;
    repeat (100) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    chk("abort_ready", int'(pif.ready), 1);
    chk("abort_clearing", int'(clearing), 0);
    chk("abort_collision", int'(collision), 0);
    for (int i = 0; i < 100; i++) ref_mem[i] = 0;
    ref_coll = 0;
    scan_idx = 0;
    do_scan(200);

    chk("final_queue_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_store.md
PIXEL_STORE -- requirements
Module: pixel_store

Interface
REQ-001 Parameter: SCREEN_W, 160, pixel columns.
REQ-002 Parameter: SCREEN_H, 120, pixel rows.
REQ-003 Parameter: BG_COLOUR, 3'd0, background/erase colour.
REQ-004 clock  in  1  system clock, all logic on rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 plot_x  in  8  write column.
REQ-007 plot_y  in  7  write row.
REQ-008 plot_colour  in  3  write colour.
REQ-009 plot  in  1  write request; transfer occurs on a cycle with plot=1 and ready=1.
REQ-010 ready  out  1  block accepts a plot request this cycle.
REQ-011 clear_screen  in  1  request to fill the whole store with BG_COLOUR.
REQ-012 clearing  out  1  clear in progress.
REQ-013 collision  out  1  sticky overlap flag.
REQ-014 clear_collision  in  1  clears collision.
REQ-015 scan_en  in  1  raster read strobe, one pixel per strobe.
REQ-016 scan_x  out  8  column of the pixel on scan_colour.
REQ-017 scan_y  out  7  row of the pixel on scan_colour.
REQ-018 scan_colour  out  3  colour read from the store.
REQ-019 scan_valid  out  1  scan outputs valid this cycle.
REQ-020 frame_start  out  1  asserted with scan_valid for pixel (0,0).

Function
REQ-021 The store SHALL hold SCREEN_W*SCREEN_H 3-bit entries at address y*160+x, computed as (y<<7)+(y<<5)+x in 15 bits.
REQ-022 The store SHALL have one write/read-modify-write port and one independent scan read port.
REQ-023 The write FSM SHALL have states IDLE, RMW_RD, RMW_WR, and CLEAR.
REQ-024 ready SHALL be 1 only in IDLE.
REQ-025 In IDLE, plot=1 with plot_x<SCREEN_W and plot_y<SCREEN_H SHALL latch address and colour, then go to RMW_RD.
REQ-026 In IDLE, an out-of-range plot SHALL be accepted and discarded with no state change and no store write.
REQ-027 RMW_RD SHALL read the old entry, then go to RMW_WR.
REQ-028 RMW_WR SHALL write the new colour and return to IDLE, so a write takes 3 cycles and back-to-back accepts occur every 3 cycles.
REQ-029 In RMW_WR, collision SHALL set when old!=BG_COLOUR and new!=BG_COLOUR.
REQ-030 collision SHALL stay set until clear_collision, clear start, or reset.
REQ-031 If clear_collision coincides with a set event, the set SHALL win.
REQ-032 In IDLE, clear_screen=1 SHALL take priority over plot, enter CLEAR, and zero collision.
REQ-033 CLEAR SHALL write BG_COLOUR to addresses 0..19199, one per cycle, with clearing=1, then return to IDLE (19200 cycles).
REQ-034 clear_screen outside IDLE SHALL be ignored.
REQ-035 Scan counters sx/sy SHALL reset to (0,0).
REQ-036 Each scan_en SHALL read (sx,sy) and present colour and coordinates with scan_valid=1 exactly 1 cycle later.
REQ-037 Each scan_en SHALL advance sx; at sx=159 it SHALL wrap sx to 0 and increment sy; at (159,119) it SHALL wrap to (0,0).
REQ-038 scan_valid SHALL be 0 in cycles not following a scan_en.
REQ-039 A scan read and a write to the same address in the same cycle SHALL return the old data.
REQ-040 Scanning SHALL continue unaffected during RMW and CLEAR.

Reset
REQ-041 During reset, state SHALL be IDLE, and collision, clearing, scan_valid, frame_start, scan_x, scan_y, and scan_colour SHALL be 0.
REQ-042 ready SHALL be 1 in the first cycle after reset release.
REQ-043 Reset mid-RMW or mid-CLEAR SHALL abort the operation without completing the pending write.
REQ-044 Store contents SHALL NOT be reset; software issues clear_screen.

Verification
REQ-045 Reset, clear_screen -> clearing=1 for 19200 cycles, ready=0 throughout, then a full scan frame reads all 0.
REQ-046 plot (10,58) colour 2 -> ready low 2 cycles; the scan then returns scan_colour=2 at (10,58) and 0 at (11,58).
REQ-047 plot (10,58) colour 2, then (10,58) colour 4 -> collision=1; clear_collision -> 0; replot same pixel with colour 0 -> collision stays 0.
REQ-048 plot (160,5) and (5,120) -> accepted in 1 cycle each, no store change, collision unchanged.
REQ-049 Continuous scan_en over 19201 strobes -> coordinates wrap 159->0 and (159,119)->(0,0), frame_start exactly on strobes 1 and 19201.
REQ-050 resetn low during cycle 100 of CLEAR -> next cycle IDLE, ready=1, clearing=0, address 100 unwritten.
